// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute control unit driving every DataPath strobe for register-register ALU ops.
// Optional single-step mode: define SINGLE_STEP_EN to insert a PAUSE state after each execute.
//
// state | meaning
// IDLE  | waiting for Start, all strobes low
// T0    | PC to MAR, PC+1 into Z
// T1    | memory read; Z to PC on first cycle only, wait for Mem_rdy
// T2    | MDR to IR
// DEC   | opcode decode, no strobes
// T3-T6 | execute steps, content depends on binary/muldiv/unary path
// HALT  | stopped until Clear
// PAUSE | single-step hold until Step (SINGLE_STEP_EN only)

module ctrl_sequencer #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        Clock_i,
   input  logic        Clear_i,
   input  logic        Start_i,
   input  logic [31:0] IR_i,
   input  logic        Mem_rdy_i,
   input  logic        Step_i,
   output logic        PCout_o,
   output logic        PCin_o,
   output logic        MARin_o,
   output logic        MDRin_o,
   output logic        MDRout_o,
   output logic        IRin_o,
   output logic        Yin_o,
   output logic        Zin_o,
   output logic        Zhighout_o,
   output logic        Zlowout_o,
   output logic        HIin_o,
   output logic        LOin_o,
   output logic        IncPC_o,
   output logic        Read_o,
   output logic [15:0] Rin_o,
   output logic [15:0] Rout_o,
   output logic [12:0] AluOp_o,
   output logic        Running_o,
   output logic        Halted_o,
   output logic        Err_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_HALT
`ifdef SINGLE_STEP_EN
      , S_PAUSE
`endif
   } state_t;

`ifdef SINGLE_STEP_EN
   localparam state_t S_LAST = S_PAUSE;
   logic unused_ir;
   assign unused_ir = ^IR_i[14:0];
`else
   localparam state_t S_LAST = S_T0;
   logic unused_in;
   assign unused_in = ^{IR_i[14:0], Step_i};
`endif

   // Saturation at all-ones keeps a 1-bit counter meaningful when WAIT_MAX=0 (wait forever).
   localparam int CW = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT_MAX);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   logic [4:0]  op;
   logic [15:0] ra_oh, rb_oh, rc_oh;
   logic        is_bin, is_md, is_un, is_nop, is_hlt;
   logic [12:0] alu_sel;

   assign op    = IR_i[31:27];
   assign ra_oh = 16'(1) << IR_i[26:23];
   assign rb_oh = 16'(1) << IR_i[22:19];
   assign rc_oh = 16'(1) << IR_i[18:15];

   always_comb begin
      is_bin  = 1'b0;
      is_md   = 1'b0;
      is_un   = 1'b0;
      is_nop  = 1'b0;
      is_hlt  = 1'b0;
      alu_sel = '0;
      case (op)
         5'b00011: begin is_bin = 1'b1; alu_sel = 13'h0001; end
         5'b00100: begin is_bin = 1'b1; alu_sel = 13'h0002; end
         5'b00101: begin is_bin = 1'b1; alu_sel = 13'h0004; end
         5'b00110: begin is_bin = 1'b1; alu_sel = 13'h0008; end
         5'b00111: begin is_bin = 1'b1; alu_sel = 13'h0010; end
         5'b01000: begin is_bin = 1'b1; alu_sel = 13'h0020; end
         5'b01001: begin is_bin = 1'b1; alu_sel = 13'h0040; end
         5'b01010: begin is_bin = 1'b1; alu_sel = 13'h0080; end
         5'b01011: begin is_bin = 1'b1; alu_sel = 13'h0100; end
         5'b01111: begin is_md  = 1'b1; alu_sel = 13'h0200; end
         5'b10000: begin is_md  = 1'b1; alu_sel = 13'h0400; end
         5'b10001: begin is_un  = 1'b1; alu_sel = 13'h0800; end
         5'b10010: begin is_un  = 1'b1; alu_sel = 13'h1000; end
         5'b11010: is_nop = 1'b1;
         5'b11011: is_hlt = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge Clock_i) begin
      if (!Clear_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (Start_i) state_d = S_T0;
         S_T0: begin
            state_d = S_T1;
            cnt_d   = '0;
         end
         S_T1: begin
            if (Mem_rdy_i) begin
               state_d = S_T2;
            end else if (WAIT_MAX != 0 && cnt_q == WAIT_CNT) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_T2: state_d = S_DEC;
         S_DEC: begin
            if (is_bin || is_md || is_un) begin
               state_d = S_T3;
            end else if (is_nop) begin
               state_d = S_T0;
            end else begin
               state_d = S_HALT;
               err_d   = !is_hlt;
            end
         end
         S_T3: state_d = S_T4;
         S_T4: state_d = is_un ? S_LAST : S_T5;
         S_T5: state_d = is_md ? S_T6 : S_LAST;
         S_T6: state_d = S_LAST;
         S_HALT: state_d = S_HALT;
`ifdef SINGLE_STEP_EN
         S_PAUSE: if (Step_i) state_d = S_T0;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      PCout_o    = 1'b0;
      PCin_o     = 1'b0;
      MARin_o    = 1'b0;
      MDRin_o    = 1'b0;
      MDRout_o   = 1'b0;
      IRin_o     = 1'b0;
      Yin_o      = 1'b0;
      Zin_o      = 1'b0;
      Zhighout_o = 1'b0;
      Zlowout_o  = 1'b0;
      HIin_o     = 1'b0;
      LOin_o     = 1'b0;
      IncPC_o    = 1'b0;
      Read_o     = 1'b0;
      Rin_o      = '0;
      Rout_o     = '0;
      AluOp_o    = '0;
      case (state_q)
         S_T0: begin
            PCout_o = 1'b1;
            MARin_o = 1'b1;
            IncPC_o = 1'b1;
            Zin_o   = 1'b1;
         end
         S_T1: begin
            Read_o  = 1'b1;
            MDRin_o = 1'b1;
            // PC reload from Z only once; later wait cycles must not re-latch it.
            if (cnt_q == '0) begin
               Zlowout_o = 1'b1;
               PCin_o    = 1'b1;
            end
         end
         S_T2: begin
            MDRout_o = 1'b1;
            IRin_o   = 1'b1;
         end
         S_T3: begin
            Rout_o = rb_oh;
            if (is_un) begin
               AluOp_o = alu_sel;
               Zin_o   = 1'b1;
            end else begin
               Yin_o = 1'b1;
            end
         end
         S_T4: begin
            if (is_un) begin
               Zlowout_o = 1'b1;
               Rin_o     = ra_oh;
            end else begin
               Rout_o  = rc_oh;
               AluOp_o = alu_sel;
               Zin_o   = 1'b1;
            end
         end
         S_T5: begin
            Zlowout_o = 1'b1;
            if (is_md) LOin_o = 1'b1;
            else       Rin_o  = ra_oh;
         end
         S_T6: begin
            Zhighout_o = 1'b1;
            HIin_o     = 1'b1;
         end
         default: ;
      endcase
   end

   assign Running_o = (state_q != S_IDLE) && (state_q != S_HALT);
   assign Halted_o  = (state_q == S_HALT);
   assign Err_o     = err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer; a second instance with WAIT_MAX=2 covers the fetch timeout.
module tb_ctrl_sequencer;

   localparam logic [13:0] B_PCOUT  = 14'h2000;
   localparam logic [13:0] B_PCIN   = 14'h1000;
   localparam logic [13:0] B_MARIN  = 14'h0800;
   localparam logic [13:0] B_MDRIN  = 14'h0400;
   localparam logic [13:0] B_MDROUT = 14'h0200;
   localparam logic [13:0] B_IRIN   = 14'h0100;
   localparam logic [13:0] B_YIN    = 14'h0080;
   localparam logic [13:0] B_ZIN    = 14'h0040;
   localparam logic [13:0] B_ZHIGH  = 14'h0020;
   localparam logic [13:0] B_ZLOW   = 14'h0010;
   localparam logic [13:0] B_HIIN   = 14'h0008;
   localparam logic [13:0] B_LOIN   = 14'h0004;
   localparam logic [13:0] B_INCPC  = 14'h0002;
   localparam logic [13:0] B_READ   = 14'h0001;

   localparam logic [13:0] S_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
   localparam logic [13:0] S_T1F = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
   localparam logic [13:0] S_T1W = B_READ | B_MDRIN;
   localparam logic [13:0] S_T2  = B_MDROUT | B_IRIN;

   localparam logic [31:0] I_ADD = 32'h1C338000;
   localparam logic [31:0] I_MUL = 32'h78118000;
   localparam logic [31:0] I_NEG = 32'h8AC80000;
   localparam logic [31:0] I_NOP = 32'hD0000000;
   localparam logic [31:0] I_HLT = 32'hD8000000;
   localparam logic [31:0] I_ILL = 32'hF8000000;

   logic clk, clear, start, mem_rdy, step;
   logic clear_w, start_w, mem_rdy_w;
   logic [31:0] ir;
   int checks, errors;

   logic a_pcout, a_pcin, a_marin, a_mdrin, a_mdrout, a_irin, a_yin, a_zin;
   logic a_zhigh, a_zlow, a_hiin, a_loin, a_incpc, a_read, a_run, a_hlt, a_err;
   logic [15:0] a_rin, a_rout;
   logic [12:0] a_alu;
   logic w_pcout, w_pcin, w_marin, w_mdrin, w_mdrout, w_irin, w_yin, w_zin;
   logic w_zhigh, w_zlow, w_hiin, w_loin, w_incpc, w_read, w_run, w_hlt, w_err;
   logic [15:0] w_rin, w_rout;
   logic [12:0] w_alu;
   logic [61:0] a_obs, w_obs;

   ctrl_sequencer dut (
      .Clock_i(clk), .Clear_i(clear), .Start_i(start), .IR_i(ir), .Mem_rdy_i(mem_rdy), .Step_i(step),
      .PCout_o(a_pcout), .PCin_o(a_pcin), .MARin_o(a_marin), .MDRin_o(a_mdrin), .MDRout_o(a_mdrout),
      .IRin_o(a_irin), .Yin_o(a_yin), .Zin_o(a_zin), .Zhighout_o(a_zhigh), .Zlowout_o(a_zlow),
      .HIin_o(a_hiin), .LOin_o(a_loin), .IncPC_o(a_incpc), .Read_o(a_read), .Rin_o(a_rin),
      .Rout_o(a_rout), .AluOp_o(a_alu), .Running_o(a_run), .Halted_o(a_hlt), .Err_o(a_err)
   );

   ctrl_sequencer #(.WAIT_MAX(2)) dut_w (
      .Clock_i(clk), .Clear_i(clear_w), .Start_i(start_w), .IR_i(ir), .Mem_rdy_i(mem_rdy_w), .Step_i(step),
      .PCout_o(w_pcout), .PCin_o(w_pcin), .MARin_o(w_marin), .MDRin_o(w_mdrin), .MDRout_o(w_mdrout),
      .IRin_o(w_irin), .Yin_o(w_yin), .Zin_o(w_zin), .Zhighout_o(w_zhigh), .Zlowout_o(w_zlow),
      .HIin_o(w_hiin), .LOin_o(w_loin), .IncPC_o(w_incpc), .Read_o(w_read), .Rin_o(w_rin),
      .Rout_o(w_rout), .AluOp_o(w_alu), .Running_o(w_run), .Halted_o(w_hlt), .Err_o(w_err)
   );

   assign a_obs = {a_pcout, a_pcin, a_marin, a_mdrin, a_mdrout, a_irin, a_yin, a_zin, a_zhigh, a_zlow,
                   a_hiin, a_loin, a_incpc, a_read, a_rin, a_rout, a_alu, a_run, a_hlt, a_err};
   assign w_obs = {w_pcout, w_pcin, w_marin, w_mdrin, w_mdrout, w_irin, w_yin, w_zin, w_zhigh, w_zlow,
                   w_hiin, w_loin, w_incpc, w_read, w_rin, w_rout, w_alu, w_run, w_hlt, w_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [61:0] ev(input logic [13:0] s, input logic [15:0] rin, input logic [15:0] rout,
                                      input logic [12:0] alu, input logic run, input logic hlt, input logic err);
      return {s, rin, rout, alu, run, hlt, err};
   endfunction

   task automatic chk(input string tag, input logic [61:0] obs, input logic [61:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called with the DUT in T0; leaves it in DEC.
   task automatic fetch(input logic [31:0] instr, input string tag);
      ir = instr;
      mem_rdy = 1'b1;
      tick(); chk({tag, "_t1"},  a_obs, ev(S_T1F, 0, 0, 0, 1, 0, 0));
      tick(); chk({tag, "_t2"},  a_obs, ev(S_T2, 0, 0, 0, 1, 0, 0));
      tick(); chk({tag, "_dec"}, a_obs, ev(0, 0, 0, 0, 1, 0, 0));
   endtask

   // Called in the last execute state; leaves the DUT in T0.
   task automatic end_exec(input string tag);
`ifdef SINGLE_STEP_EN
      tick(); chk({tag, "_pause"},  a_obs, ev(0, 0, 0, 0, 1, 0, 0));
      tick(); chk({tag, "_pause2"}, a_obs, ev(0, 0, 0, 0, 1, 0, 0));
      step = 1'b1;
      tick();
      step = 1'b0;
      chk({tag, "_next_t0"}, a_obs, ev(S_T0, 0, 0, 0, 1, 0, 0));
`else
      step = 1'b1;
      tick();
      step = 1'b0;
      chk({tag, "_next_t0"}, a_obs, ev(S_T0, 0, 0, 0, 1, 0, 0));
`endif
   endtask

   initial begin
      checks = 0; errors = 0;
      clear = 1'b0; start = 1'b0; mem_rdy = 1'b0; step = 1'b0; ir = '0;
      clear_w = 1'b0; start_w = 1'b0; mem_rdy_w = 1'b0;

      tick(); tick();
      chk("reset", a_obs, ev(0, 0, 0, 0, 0, 0, 0));
      clear = 1'b1;
      tick(); chk("idle_hold", a_obs, ev(0, 0, 0, 0, 0, 0, 0));

      // add R8,R6,R7
      start = 1'b1; ir = I_ADD; mem_rdy = 1'b1;
      tick(); chk("add_t0", a_obs, ev(S_T0, 0, 0, 0, 1, 0, 0));
      start = 1'b0;
      fetch(I_ADD, "add");
      tick(); chk("add_t3", a_obs, ev(B_YIN, 0, 16'h0040, 0, 1, 0, 0));
      tick(); chk("add_t4", a_obs, ev(B_ZIN, 0, 16'h0080, 13'h0001, 1, 0, 0));
      tick(); chk("add_t5", a_obs, ev(B_ZLOW, 16'h0100, 0, 0, 1, 0, 0));
      end_exec("add");

      // mul R2,R3 with Mem_rdy low for the first three T1 cycles
      ir = I_MUL; mem_rdy = 1'b0;
      tick(); chk("mul_t1_c1", a_obs, ev(S_T1F, 0, 0, 0, 1, 0, 0));
      tick(); chk("mul_t1_c2", a_obs, ev(S_T1W, 0, 0, 0, 1, 0, 0));
      tick(); chk("mul_t1_c3", a_obs, ev(S_T1W, 0, 0, 0, 1, 0, 0));
      tick(); chk("mul_t1_c4", a_obs, ev(S_T1W, 0, 0, 0, 1, 0, 0));
      mem_rdy = 1'b1;
      tick(); chk("mul_t2",  a_obs, ev(S_T2, 0, 0, 0, 1, 0, 0));
      tick(); chk("mul_dec", a_obs, ev(0, 0, 0, 0, 1, 0, 0));
      tick(); chk("mul_t3",  a_obs, ev(B_YIN, 0, 16'h0004, 0, 1, 0, 0));
      tick(); chk("mul_t4",  a_obs, ev(B_ZIN, 0, 16'h0008, 13'h0200, 1, 0, 0));
      tick(); chk("mul_t5",  a_obs, ev(B_ZLOW | B_LOIN, 0, 0, 0, 1, 0, 0));
      tick(); chk("mul_t6",  a_obs, ev(B_ZHIGH | B_HIIN, 0, 0, 0, 1, 0, 0));
      end_exec("mul");

      // neg R5,R9
      fetch(I_NEG, "neg");
      tick(); chk("neg_t3", a_obs, ev(B_ZIN, 0, 16'h0200, 13'h0800, 1, 0, 0));
      tick(); chk("neg_t4", a_obs, ev(B_ZLOW, 16'h0020, 0, 0, 1, 0, 0));
      end_exec("neg");

      fetch(I_NOP, "nop");
      tick(); chk("nop_t0", a_obs, ev(S_T0, 0, 0, 0, 1, 0, 0));

      // Clear mid-instruction: no write-back cycle follows
      fetch(I_ADD, "add2");
      tick(); chk("add2_t3", a_obs, ev(B_YIN, 0, 16'h0040, 0, 1, 0, 0));
      tick(); chk("add2_t4", a_obs, ev(B_ZIN, 0, 16'h0080, 13'h0001, 1, 0, 0));
      clear = 1'b0;
      tick(); chk("abort_idle", a_obs, ev(0, 0, 0, 0, 0, 0, 0));
      clear = 1'b1;
      tick(); chk("abort_idle2", a_obs, ev(0, 0, 0, 0, 0, 0, 0));
      start = 1'b1;
      tick(); chk("restart_t0", a_obs, ev(S_T0, 0, 0, 0, 1, 0, 0));
      start = 1'b0;

      // HALT opcode: no error, Start ignored
      fetch(I_HLT, "hlt");
      tick(); chk("hlt_state", a_obs, ev(0, 0, 0, 0, 0, 1, 0));
      start = 1'b1;
      tick(); chk("hlt_start_ign", a_obs, ev(0, 0, 0, 0, 0, 1, 0));
      start = 1'b0;

      clear = 1'b0; tick(); clear = 1'b1;
      start = 1'b1;
      tick(); chk("ill_t0", a_obs, ev(S_T0, 0, 0, 0, 1, 0, 0));
      start = 1'b0;
      fetch(I_ILL, "ill");
      tick(); chk("ill_halt", a_obs, ev(0, 0, 0, 0, 0, 1, 1));
      start = 1'b1;
      tick(); chk("ill_start_ign", a_obs, ev(0, 0, 0, 0, 0, 1, 1));
      clear = 1'b0;
      tick(); chk("clear_beats_start", a_obs, ev(0, 0, 0, 0, 0, 0, 0));
      clear = 1'b1; start = 1'b0;
      tick(); chk("idle_after_clear", a_obs, ev(0, 0, 0, 0, 0, 0, 0));

      // WAIT_MAX=2 instance, Mem_rdy stuck low
      clear_w = 1'b1; start_w = 1'b1;
      tick(); chk("to_t0", w_obs, ev(S_T0, 0, 0, 0, 1, 0, 0));
      start_w = 1'b0;
      tick(); chk("to_t1_c1", w_obs, ev(S_T1F, 0, 0, 0, 1, 0, 0));
      tick(); chk("to_t1_c2", w_obs, ev(S_T1W, 0, 0, 0, 1, 0, 0));
      tick(); chk("to_t1_c3", w_obs, ev(S_T1W, 0, 0, 0, 1, 0, 0));
      tick(); chk("to_halt",  w_obs, ev(0, 0, 0, 0, 0, 1, 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
